// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM encodings and counter width
// for the RAM1 SRAM controller.
package sram_ctrl_pkg;

  localparam int SRAM_STROBE_CNT_W = 4;

  typedef enum logic [1:0] {
    SRAM_ST_IDLE   = 2'd0,
    SRAM_ST_SETUP  = 2'd1,
    SRAM_ST_STROBE = 2'd2,
    SRAM_ST_HOLD   = 2'd3
  } sram_st_e;

  function automatic logic [SRAM_STROBE_CNT_W-1:0]
    strobe_init(input int cycles);
    return SRAM_STROBE_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_io_pad.sv
// sram_io_pad: tristate driver for the SRAM data bus,
// keeps the inout away from the controller FSM.
module sram_io_pad #(
  parameter int W = 16
) (
  input  logic         drv_en,
  input  logic [W-1:0] dout,
  output logic [W-1:0] din,
  inout  wire  [W-1:0] pad
);

  assign pad = drv_en ? dout : {W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: MEM-stage responder that sequences RAM1
// async SRAM pins through setup, strobe and hold phases.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              stall,
  output logic              ram1_en,
  output logic              ram1_oe,
  output logic              ram1_we,
  output logic [ADDR_W-1:0] ram1_addr,
  inout  wire  [DATA_W-1:0] ram1_data
);

  localparam logic [SRAM_STROBE_CNT_W-1:0] CNT_INIT =
    strobe_init(STROBE_CYCLES);

  sram_st_e                    st_q, st_d;
  logic [SRAM_STROBE_CNT_W-1:0] cnt_q, cnt_d;
  logic                        is_wr_q, is_wr_d;
  logic [DATA_W-1:0]           wdata_q, wdata_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [DATA_W-1:0]           rdata_q, rdata_d;
  logic                        en_q, en_d;
  logic                        oe_q, oe_d;
  logic                        we_q, we_d;
  logic                        drv_q, drv_d;
  logic                        ready_q, ready_d;
  logic                        rsp_q, rsp_d;
  logic [DATA_W-1:0]           din;

  sram_io_pad #(.W(DATA_W)) u_pad (
    .drv_en (drv_q),
    .dout   (wdata_q),
    .din    (din),
    .pad    (ram1_data)
  );

  // Pin values are computed for the next state so every
  // SRAM strobe comes straight from a flop.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    en_d    = en_q;
    oe_d    = oe_q;
    we_d    = we_q;
    drv_d   = drv_q;
    ready_d = ready_q;
    rsp_d   = 1'b0;
    unique case (st_q)
      SRAM_ST_IDLE: begin
        if (req_valid && ready_q) begin
          st_d    = SRAM_ST_SETUP;
          is_wr_d = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          en_d    = 1'b0;
          oe_d    = req_we;
          we_d    = 1'b1;
          drv_d   = req_we;
          ready_d = 1'b0;
        end
      end
      SRAM_ST_SETUP: begin
        st_d  = SRAM_ST_STROBE;
        cnt_d = CNT_INIT;
        we_d  = ~is_wr_q;
        oe_d  = is_wr_q;
      end
      SRAM_ST_STROBE: begin
        if (cnt_q == '0) begin
          st_d  = SRAM_ST_HOLD;
          we_d  = 1'b1;
          oe_d  = 1'b1;
          rsp_d = 1'b1;
          if (!is_wr_q) rdata_d = din;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SRAM_ST_HOLD: begin
        st_d    = SRAM_ST_IDLE;
        en_d    = 1'b1;
        drv_d   = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        st_d    = SRAM_ST_IDLE;
        en_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        drv_d   = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= SRAM_ST_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      en_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drv_q   <= 1'b0;
      ready_q <= 1'b1;
      rsp_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drv_q   <= drv_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;
  assign stall     = req_valid && !ready_q;
  assign ram1_en   = en_q;
  assign ram1_oe   = oe_q;
  assign ram1_we   = we_q;
  assign ram1_addr = addr_q;

endmodule
